// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative shift-add multiplier / restoring divider with
//               architectural HI/LO registers and MTHI/MTLO writes.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_FIX  = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_isDiv;
    logic               r_neg;
    logic               r_remNeg;
    logic               r_divZero;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_isSigned;
    logic               w_signA;
    logic               w_signB;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_isSigned = (op == c_OP_MULT) || (op == c_OP_DIV);
    assign w_signA    = w_isSigned & srcA[WIDTH-1];
    assign w_signB    = w_isSigned & srcB[WIDTH-1];
    assign w_magA     = w_signA ? -srcA : srcA;
    assign w_magB     = w_signB ? -srcB : srcB;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // Divide: acc = {partial remainder, remaining dividend bits}, shifted left;
    // the MSB of the difference doubles as the borrow flag.
    assign w_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff  = w_shift - {1'b0, r_opnd};

    assign w_prod  = r_neg ? -r_acc : r_acc;
    assign w_quo   = r_divZero ? {WIDTH{1'b1}}
                   : (r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem   = r_remNeg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_isDiv   <= 1'b0;
            r_neg     <= 1'b0;
            r_remNeg  <= 1'b0;
            r_divZero <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        if (op == c_OP_MTHI) begin
                            r_hi   <= srcA;
                            r_done <= 1'b1;
                        end else if (op == c_OP_MTLO) begin
                            r_lo   <= srcA;
                            r_done <= 1'b1;
                        end else if (!op[2]) begin
                            r_isDiv   <= op[1];
                            r_neg     <= w_signA ^ w_signB;
                            r_remNeg  <= w_signA;
                            r_divZero <= op[1] && (srcB == '0);
                            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_magA : w_magB)};
                            r_opnd    <= op[1] ? w_magB : w_magA;
                            r_cnt     <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= c_S_RUN;
                        end
                    end
                end
                c_S_RUN: begin
                    if (r_isDiv) begin
                        if (!w_diff[WIDTH])
                            r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                        else
                            r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
                    end else begin
                        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST)
                        r_state <= c_S_FIX;
                end
                c_S_FIX: begin
                    if (r_isDiv) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors    = 0;
    int miscompares = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .srcA  (srcA),
        .srcB  (srcB),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present a request for one edge, then scramble the operands.
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        srcA  = $urandom;
        srcB  = $urandom;
    endtask

    // Called one step after the accept edge; returns in the done cycle.
    task automatic waitDone(input logic [31:0] h0, input logic [31:0] l0,
                            output int cyc, output bit busyOk, output bit holdOk);
        cyc    = 0;
        busyOk = busy;
        holdOk = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                if (busy) busyOk = 1'b0;
                break;
            end
            if (!busy) busyOk = 1'b0;
            if (hi !== h0 || lo !== l0) holdOk = 1'b0;
        end
    endtask

    task automatic doOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
        logic [31:0] h0, l0;
        int  cyc;
        bit  busyOk, holdOk;
        h0 = hi;
        l0 = lo;
        launch(o, a, b);
        waitDone(h0, l0, cyc, busyOk, holdOk);
        check({tag, "_latency"}, cyc, 33);
        check({tag, "_busy"}, busyOk, 1);
        check({tag, "_hold"}, holdOk, 1);
        check({tag, "_hi"}, hi, expHi);
        check({tag, "_lo"}, lo, expLo);
    endtask

    initial begin
        int  cyc;
        int  pulses;
        bit  busyOk, holdOk;
        logic [31:0] h0, l0;

        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        srcA  = '0;
        srcB  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        doOp("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        doOp("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB);
        doOp("div_neg",   3'b010, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
        doOp("divu",      3'b011, 32'd100,       32'd7,          32'd2,         32'd14);
        doOp("divu_zero", 3'b011, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF);
        doOp("div_zero",  3'b010, 32'hFFFF_FFF0, 32'd0,          32'hFFFF_FFF0, 32'hFFFF_FFFF);
        doOp("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000);

        // MTHI / MTLO: immediate write, done pulse, never busy
        launch(3'b100, 32'hA5A5_A5A5, 32'd0);
        check("mthi_hi", hi, 32'hA5A5_A5A5);
        check("mthi_lo", lo, 32'h8000_0000);
        check("mthi_done", done, 1);
        check("mthi_busy", busy, 0);
        @(posedge clk);
        #1;
        check("mthi_done_clear", done, 0);
        launch(3'b101, 32'h5A5A_5A5A, 32'd0);
        check("mtlo_lo", lo, 32'h5A5A_5A5A);
        check("mtlo_hi", hi, 32'hA5A5_A5A5);
        check("mtlo_done", done, 1);

        // Reserved ops leave everything untouched
        launch(3'b110, 32'h1111_1111, 32'd3);
        check("rsv110_busy", busy, 0);
        check("rsv110_done", done, 0);
        launch(3'b111, 32'h2222_2222, 32'd3);
        check("rsv111_busy", busy, 0);
        check("rsv111_done", done, 0);
        check("rsv_hi", hi, 32'hA5A5_A5A5);
        check("rsv_lo", lo, 32'h5A5A_5A5A);

        // Second start during RUN is dropped
        launch(3'b001, 32'd3, 32'd5);
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 5) begin
                start = 1'b1;
                op    = 3'b011;
                srcA  = 32'd100;
                srcB  = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
        start = 1'b0;
        check("busy_start_latency", cyc, 33);
        check("busy_start_hi", hi, 32'd0);
        check("busy_start_lo", lo, 32'd15);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("busy_start_not_queued", pulses, 0);

        // Reset in the middle of a multiply
        launch(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_busy", busy, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_done", pulses, 0);

        // Start in the done cycle is accepted
        launch(3'b001, 32'd6, 32'd7);
        waitDone(32'd0, 32'd0, cyc, busyOk, holdOk);
        check("chain1_latency", cyc, 33);
        check("chain1_lo", lo, 32'd42);
        h0    = hi;
        l0    = lo;
        start = 1'b1;
        op    = 3'b011;
        srcA  = 32'd100;
        srcB  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("chain2_accept_busy", busy, 1);
        waitDone(h0, l0, cyc, busyOk, holdOk);
        check("chain2_latency", cyc, 33);
        check("chain2_hold", holdOk, 1);
        check("chain2_hi", hi, 32'd2);
        check("chain2_lo", lo, 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
